// File: rtl/vsmac_seq_if.sv
// Signal bundle between vsmac_seq and its surroundings: command/result, x buffer load port,
// weight memory read port and the vsmac drive/return lanes.
interface vsmac_seq_if #(
  parameter int SIZE     = 3,
  parameter int MAX_COLS = 16
);
  localparam int AW = $clog2(MAX_COLS);
  localparam int CW = $clog2(MAX_COLS + 1);

  // Protocol: start is a one-cycle request accepted only while busy=0; the product
  // completes with a one-cycle done/result_valid pulse, and result holds until the next capture.
  logic                start;
  logic [CW-1:0]       num_cols;
  logic                x_wr_en;
  logic [AW-1:0]       x_wr_addr;
  logic [7:0]          x_wr_data;
  logic                w_rd_en;
  logic [AW-1:0]       w_rd_addr;
  logic [8*SIZE-1:0]   w_rd_data;
  logic                mac_reset;
  logic                mac_enable;
  logic [8*SIZE-1:0]   mac_a;
  logic [7:0]          mac_b;
  logic [8*SIZE-1:0]   mac_out;
  logic                busy;
  logic                done;
  logic [8*SIZE-1:0]   result;
  logic                result_valid;
  logic [2:0]          dbg_state;

  modport master (
    output start, num_cols, x_wr_en, x_wr_addr, x_wr_data, w_rd_data, mac_out,
    input  w_rd_en, w_rd_addr, mac_reset, mac_enable, mac_a, mac_b,
           busy, done, result, result_valid, dbg_state
  );

  modport slave (
    input  start, num_cols, x_wr_en, x_wr_addr, x_wr_data, w_rd_data, mac_out,
    output w_rd_en, w_rd_addr, mac_reset, mac_enable, mac_a, mac_b,
           busy, done, result, result_valid, dbg_state
  );
endinterface

// File: rtl/vsmac_seq.sv
// Sequencer feeding vsmac one weight column per cycle against a buffered x vector,
// then draining the MAC pipeline and capturing the accumulated product.
module vsmac_seq #(
  parameter int SIZE     = 3,
  parameter int MAX_COLS = 16,
  parameter int MAC_LAT  = 3
) (
  input  logic        clk,
  input  logic        reset,
  vsmac_seq_if.slave  bus
);
  localparam int AW = $clog2(MAX_COLS);
  localparam int CW = $clog2(MAX_COLS + 1);
  localparam int DW = $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     n_q, k_q;
  logic [DW-1:0]     d_q;
  logic [7:0]        b_q;
  logic [8*SIZE-1:0] result_q;
  logic [7:0]        x_buf [MAX_COLS];

  logic [CW-1:0]     n_in;
  logic [CW-1:0]     k_next;
  logic              more_cols;
  logic              last_drain;
  logic              w_rd_en, mac_reset, mac_enable, busy, done;
  logic [AW-1:0]     w_rd_addr;

  assign n_in       = (bus.num_cols > CW'(MAX_COLS)) ? CW'(MAX_COLS) : bus.num_cols;
  assign k_next     = k_q + CW'(1);
  assign more_cols  = k_next < n_q;
  assign last_drain = d_q == DW'(MAC_LAT - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    w_rd_en    = 1'b0;
    w_rd_addr  = '0;
    mac_reset  = 1'b0;
    mac_enable = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start) state_n = (n_in == '0) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        mac_reset = 1'b1;
        w_rd_en   = 1'b1;
        state_n   = S_ISSUE;
      end
      S_ISSUE: begin
        mac_enable = 1'b1;
        // Prefetch the next column so it lands on w_rd_data exactly when it is issued.
        if (more_cols) begin
          w_rd_en   = 1'b1;
          w_rd_addr = AW'(k_next);
        end else begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        mac_enable = 1'b1;
        if (last_drain) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // b_q is loaded one cycle ahead so x[k] meets the column returned by the 1-cycle memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q      <= '0;
      k_q      <= '0;
      d_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          k_q <= '0;
          d_q <= '0;
          b_q <= '0;
          if (bus.start) begin
            n_q <= n_in;
            if (n_in == '0) result_q <= '0;
          end
        end
        S_CLEAR: begin
          k_q <= '0;
          d_q <= '0;
          b_q <= x_buf[0];
        end
        S_ISSUE: begin
          if (more_cols) begin
            k_q <= k_next;
            b_q <= x_buf[AW'(k_next)];
          end else begin
            b_q <= '0;
          end
        end
        S_DRAIN: begin
          d_q <= d_q + DW'(1);
          if (last_drain) result_q <= bus.mac_out;
        end
        default: b_q <= '0;
      endcase
    end
  end

  // The x buffer survives reset and only accepts writes while idle.
  always_ff @(posedge clk) begin
    if (bus.x_wr_en && state == S_IDLE && int'(bus.x_wr_addr) < MAX_COLS)
      x_buf[bus.x_wr_addr] <= bus.x_wr_data;
  end

  assign bus.w_rd_en      = w_rd_en;
  assign bus.w_rd_addr    = w_rd_addr;
  assign bus.mac_reset    = mac_reset;
  assign bus.mac_enable   = mac_enable;
  assign bus.mac_a        = (state == S_ISSUE) ? bus.w_rd_data : '0;
  assign bus.mac_b        = b_q;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.result_valid = done;
  assign bus.result       = result_q;
  assign bus.dbg_state    = state;
endmodule
